// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
// INST_LOADER_CHECKSUM_EN adds the CHK state for the trailing XOR byte.
package inst_mem_loader_pkg;

  localparam int ADDR_W_DEF     = 12;
  localparam int DATA_W_DEF     = 19;
  localparam int BYTES_PER_WORD = 3;
  localparam int LEN_W          = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_B0,
    ST_B1,
    ST_B2,
`ifdef INST_LOADER_CHECKSUM_EN
    ST_CHK,
`endif
    ST_FIN
  } state_t;

endpackage

// File: rtl/inst_word_assembler.sv
// Collects the low bytes of each word and registers the assembled write data
// when the top byte arrives, so wr_data is stable through the write cycle.
module inst_word_assembler
  import inst_mem_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_b0,
  input  logic              ld_b1,
  input  logic              ld_b2,
  input  logic [7:0]        in_byte,
  output logic [DATA_W-1:0] wr_data
);

  // Bits of the top byte that survive; the rest of B2 is ignored.
  localparam int HI_W = DATA_W - 8 * (BYTES_PER_WORD - 1);

  logic [7:0] b0;
  logic [7:0] b1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      b0      <= '0;
      b1      <= '0;
      wr_data <= '0;
    end else begin
      if (ld_b0) b0 <= in_byte;
      if (ld_b1) b1 <= in_byte;
      if (ld_b2) wr_data <= {in_byte[HI_W-1:0], b1, b0};
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Byte-stream instruction-memory loader: length header, then 3-byte words.
// Define INST_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_stall,
  output logic              done,
  output logic              err
);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] len_m1;
  logic             accept;
  logic             start_acc;
  logic             last_word;

  assign accept    = in_valid & in_ready;
  assign start_acc = (state == ST_IDLE) & start;
  assign cpu_stall = (state != ST_IDLE);
  // wr_addr only advances after a write, so it equals the index of the word
  // whose B2 is on the bus.
  assign last_word = (wr_addr == ADDR_W'(len_m1));

  // NOTE: every always_comb output gets a default first; a missing branch
  // would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_LEN_LO;
      ST_LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_B0;
      end
      ST_B0: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_B1;
      end
      ST_B1: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_B2;
      end
      ST_B2: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef INST_LOADER_CHECKSUM_EN
          state_nxt = last_word ? ST_CHK : ST_B0;
`else
          state_nxt = last_word ? ST_FIN : ST_B0;
`endif
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CHK: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_FIN;
      end
`endif
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      len_m1  <= '0;
    end else begin
      wr_en <= accept & (state == ST_B2);
      if (start_acc)                wr_addr <= '0;
      else if (wr_en && !last_word) wr_addr <= wr_addr + 1'b1;
      if (accept && state == ST_LEN_LO) len_m1[7:0]  <= in_byte;
      if (accept && state == ST_LEN_HI) len_m1[11:8] <= in_byte[3:0];
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
      done <= 1'b0;
      err  <= 1'b0;
    end else if (start_acc) begin
      csum <= '0;
      done <= 1'b0;
      err  <= 1'b0;
    end else if (accept && state == ST_CHK) begin
      if (in_byte == csum) done <= 1'b1;
      else                 err  <= 1'b1;
    end else if (accept) begin
      csum <= csum ^ in_byte;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst)                   done <= 1'b0;
    else if (start_acc)        done <= 1'b0;
    else if (state == ST_FIN)  done <= 1'b1;
  end

  assign err = 1'b0;
`endif

  inst_word_assembler #(.DATA_W(DATA_W)) u_asm (
    .clk     (clk),
    .rst     (rst),
    .ld_b0   (accept & (state == ST_B0)),
    .ld_b1   (accept & (state == ST_B1)),
    .ld_b2   (accept & (state == ST_B2)),
    .in_byte (in_byte),
    .wr_data (wr_data)
  );

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader: the driver pushes expected writes,
// a negedge monitor pops and compares them whenever wr_en is seen.
module tb_inst_mem_loader;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 19;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        in_byte = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              cpu_stall;
  logic              done;
  logic              err;

  inst_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_stall (cpu_stall),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t        sb[$];
  logic [7:0] wb[$];
  int         tests = 0;
  int         fails = 0;
  int         pulses = 0;
  int         last_addr = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wr_t e;
      pulses++;
      last_addr = int'(wr_addr);
      if (sb.size() == 0) begin
        check("unexpected_write", {20'd0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("wr_addr", {20'd0, wr_addr}, e.addr);
        check("wr_data", {13'd0, wr_data}, e.data);
      end
    end
  end

  task automatic fill_random(input int n);
    wb.delete();
    for (int i = 0; i < 3 * n; i++) wb.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit pulse_start);
    bit acc = 0;
    int budget = 0;
    while (!acc) begin
      @(negedge clk);
      in_byte  = b;
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      start    = pulse_start;
      acc      = in_valid && in_ready;
      @(posedge clk);
      budget++;
      if (!acc && budget > 1000) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("stall_after_start", cpu_stall, 1);
  endtask

  // Sends one complete load from lo/hi and the word bytes in wb.
  task automatic run_load(input logic [7:0] lo, input logic [7:0] hi,
                          input bit gaps, input bit corrupt, input bit start_mid);
    int n;
    int budget;
    logic [7:0] csum;
    logic [7:0] b0, b1, b2;
    bit exp_done, exp_err;
    n = (int'(hi & 8'h0F) * 256 + int'(lo)) + 1;
    pulses = 0;
    last_addr = -1;
    do_start();
    csum = lo ^ hi;
    send_byte(lo, gaps, 1'b0);
    send_byte(hi, gaps, 1'b0);
    for (int k = 0; k < n; k++) begin
      b0 = wb[3*k]; b1 = wb[3*k+1]; b2 = wb[3*k+2];
      send_byte(b0, gaps, 1'b0);
      send_byte(b1, gaps, start_mid && k == 0);
      send_byte(b2, gaps, 1'b0);
      sb.push_back('{k, int'(b2 & 8'h07) * 65536 + int'(b1) * 256 + int'(b0)});
      csum = csum ^ b0 ^ b1 ^ b2;
    end
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(corrupt ? (csum ^ 8'h5A) : csum, gaps, 1'b0);
    exp_done = !corrupt;
    exp_err  = corrupt;
`else
    exp_done = 1'b1;
    exp_err  = 1'b0;
    if (corrupt) exp_err = 1'b0;
`endif
    @(negedge clk);
    in_valid = 1'b0;
    budget = 0;
    while (done !== 1'b1 && err !== 1'b1 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    check("done", done, exp_done);
    check("err", err, exp_err);
    @(negedge clk);
    check("stall_after_fin", cpu_stall, 0);
    check("ready_idle", in_ready, 0);
    check("write_count", pulses, n);
    check("last_addr", last_addr, n - 1);
    check("sb_empty", sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, {20'd0, wr_addr}, 0);
    check({tag, "_wr_data"}, {13'd0, wr_data}, 0);
    check({tag, "_cpu_stall"}, cpu_stall, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("reset");

    // Valid data without a start must not be taken.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_byte  = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1 check("idle_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;

    // Nominal stream, then the same stream with random gaps.
    wb = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h07};
    run_load(8'h02, 8'h00, 1'b0, 1'b0, 1'b0);
    wb = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h07};
    run_load(8'h02, 8'h00, 1'b1, 1'b0, 1'b0);

    // Masked top byte and ignored LEN_HI upper nibble.
    wb = '{8'h00, 8'h00, 8'hF8};
    run_load(8'h00, 8'hF0, 1'b0, 1'b0, 1'b0);

    // Random loads, one with a start pulse mid-load.
    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(1, 20);
      fill_random(n);
      run_load(8'(n - 1), 8'($urandom_range(0, 15)) << 4, 1'b1, 1'b0, t == 1);
    end

    // Corrupted checksum byte (only meaningful with the checksum build).
    fill_random(2);
    run_load(8'h01, 8'h00, 1'b1, 1'b1, 1'b0);

    // Reset after the first of three words.
    fill_random(3);
    pulses = 0;
    do_start();
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(wb[0], 1'b0, 1'b0);
    send_byte(wb[1], 1'b0, 1'b0);
    send_byte(wb[2], 1'b0, 1'b0);
    sb.push_back('{0, int'(wb[2] & 8'h07) * 65536 + int'(wb[1]) * 256 + int'(wb[0])});
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midreset");
    check("midreset_writes", pulses, 1);
    fill_random(3);
    run_load(8'h02, 8'h00, 1'b1, 1'b0, 1'b0);

    // Full depth: 4096 words, no wrap.
    fill_random(4096);
    run_load(8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1);
  end

endmodule
